// File: rtl/card_game_ctrl_pkg.sv
// Shared definitions for the card game controller: card state codes,
// register-file field positions, colour table and FSM state encoding.
package card_game_ctrl_pkg;

  localparam logic [1:0] CARD_OFF  = 2'b00;
  localparam logic [1:0] CARD_UP   = 2'b01;
  localparam logic [1:0] CARD_DOWN = 2'b10;

  localparam int CARD_W    = 14;
  localparam int COLOR_W   = 12;
  localparam int COLOR_MSB = 13;
  localparam int COLOR_LSB = 2;
  localparam int STATE_MSB = 1;
  localparam int STATE_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_WAIT1 = 4'd2,
    ST_READ1 = 4'd3,
    ST_WAIT2 = 4'd4,
    ST_READ2 = 4'd5,
    ST_SHOW  = 4'd6,
    ST_RES1  = 4'd7,
    ST_RES2  = 4'd8,
    ST_DONE  = 4'd9
  } state_t;

  // Eight pair colours as 4-bit r,g,b; every entry must be distinct.
  function automatic logic [COLOR_W-1:0] color_lut(input logic [2:0] idx);
    logic [COLOR_W-1:0] c;
    case (idx)
      3'd0:    c = 12'hF00;
      3'd1:    c = 12'h0F0;
      3'd2:    c = 12'h00F;
      3'd3:    c = 12'hFF0;
      3'd4:    c = 12'h0FF;
      3'd5:    c = 12'hF0F;
      3'd6:    c = 12'hFFF;
      default: c = 12'hF80;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/card_game_ctrl_show_timer.sv
// Loadable down-counter: start loads a value, done is high once the count
// has reached zero.
module show_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/card_game_ctrl.sv
// Memory-game controller: deals the deck into the card register file,
// sequences pick/compare/show/resolve turns and keeps score.
module card_game_ctrl
  import card_game_ctrl_pkg::*;
#(
  parameter int N_PAIRS     = 8,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  seed,
  input  logic        pick_valid,
  input  logic [3:0]  pick_idx,
  output logic        pick_ready,
  output logic        pick_err,
  input  logic        disp_req,
  input  logic [3:0]  disp_addr,
  output logic [13:0] disp_data,
  output logic        rf_w_enable,
  output logic [3:0]  rf_w_address,
  output logic [13:0] rf_w_data,
  output logic [3:0]  rf_r_address,
  input  logic [13:0] rf_r_data,
  output logic        busy,
  output logic [3:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        game_over
);

  localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          seed_q, seed_d;
  logic [3:0]          init_cnt_q, init_cnt_d;
  logic [3:0]          idx1_q, idx1_d;
  logic [3:0]          idx2_q, idx2_d;
  logic [COLOR_W-1:0]  color1_q, color1_d;
  logic [COLOR_W-1:0]  color2_q, color2_d;
  logic [3:0]          pairs_q, pairs_d;
  logic [7:0]          moves_q, moves_d;
  logic                w_en_q, w_en_d;
  logic [3:0]          w_addr_q, w_addr_d;
  logic [CARD_W-1:0]   w_data_q, w_data_d;
  logic                pick_err_q, pick_err_d;
  logic                timer_start, timer_done;
  logic                match;
  logic [1:0]          res_code;
  logic [3:0]          deal_pos;

  show_timer #(.WIDTH(TIMER_W)) u_show_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (timer_start),
    .load_value (SHOW_LOAD),
    .done       (timer_done)
  );

  assign match    = (color1_q == color2_q);
  assign res_code = match ? CARD_OFF : CARD_DOWN;
  assign deal_pos = init_cnt_q + seed_q;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    init_cnt_d  = init_cnt_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    color1_d    = color1_q;
    color2_d    = color2_q;
    pairs_d     = pairs_q;
    moves_d     = moves_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    pick_err_d  = 1'b0;
    timer_start = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          seed_d     = seed;
          pairs_d    = '0;
          moves_d    = '0;
          init_cnt_d = '0;
          state_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        w_en_d     = 1'b1;
        w_addr_d   = init_cnt_q;
        w_data_d   = {color_lut(deal_pos[3:1]), CARD_DOWN};
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == 4'd15) begin
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (pick_valid) begin
          idx1_d  = pick_idx;
          state_d = ST_READ1;
        end
      end
      ST_WAIT2: begin
        if (pick_valid) begin
          idx2_d  = pick_idx;
          state_d = ST_READ2;
        end
      end
      // The display owns the read port while disp_req is high, so stall.
      ST_READ1: begin
        if (!disp_req) begin
          if (rf_r_data[STATE_MSB:STATE_LSB] == CARD_DOWN) begin
            w_en_d   = 1'b1;
            w_addr_d = idx1_q;
            w_data_d = {rf_r_data[COLOR_MSB:COLOR_LSB], CARD_UP};
            color1_d = rf_r_data[COLOR_MSB:COLOR_LSB];
            state_d  = ST_WAIT2;
          end else begin
            pick_err_d = 1'b1;
            state_d    = ST_WAIT1;
          end
        end
      end
      ST_READ2: begin
        if (!disp_req) begin
          if (rf_r_data[STATE_MSB:STATE_LSB] == CARD_DOWN) begin
            w_en_d      = 1'b1;
            w_addr_d    = idx2_q;
            w_data_d    = {rf_r_data[COLOR_MSB:COLOR_LSB], CARD_UP};
            color2_d    = rf_r_data[COLOR_MSB:COLOR_LSB];
            timer_start = 1'b1;
            state_d     = ST_SHOW;
          end else begin
            pick_err_d = 1'b1;
            state_d    = ST_WAIT2;
          end
        end
      end
      ST_SHOW: begin
        if (timer_done) begin
          state_d = ST_RES1;
        end
      end
      ST_RES1: begin
        w_en_d   = 1'b1;
        w_addr_d = idx1_q;
        w_data_d = {color1_q, res_code};
        state_d  = ST_RES2;
      end
      ST_RES2: begin
        w_en_d   = 1'b1;
        w_addr_d = idx2_q;
        w_data_d = {color2_q, res_code};
        moves_d  = (moves_q == 8'd255) ? moves_q : moves_q + 8'd1;
        if (match) begin
          pairs_d = pairs_q + 4'd1;
        end
        state_d = (pairs_d == 4'(N_PAIRS)) ? ST_DONE : ST_WAIT1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seed_q     <= '0;
      init_cnt_q <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      color1_q   <= '0;
      color2_q   <= '0;
      pairs_q    <= '0;
      moves_q    <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      pick_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      init_cnt_q <= init_cnt_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      color1_q   <= color1_d;
      color2_q   <= color2_d;
      pairs_q    <= pairs_d;
      moves_q    <= moves_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      pick_err_q <= pick_err_d;
    end
  end

  assign pick_ready   = (state_q == ST_WAIT1) || (state_q == ST_WAIT2);
  assign busy         = !((state_q == ST_IDLE) || (state_q == ST_WAIT1) ||
                          (state_q == ST_WAIT2) || (state_q == ST_DONE));
  assign game_over    = (state_q == ST_DONE);
  assign pick_err     = pick_err_q;
  assign rf_w_enable  = w_en_q;
  assign rf_w_address = w_addr_q;
  assign rf_w_data    = w_data_q;
  assign pairs_found  = pairs_q;
  assign moves        = moves_q;
  assign disp_data    = rf_r_data;
  assign rf_r_address = disp_req ? disp_addr :
                        ((state_q == ST_READ2) ? idx2_q : idx1_q);

endmodule

// File: tb/tb_card_game_ctrl.sv
// Self-checking bench for card_game_ctrl: models the register file and checks
// directed and randomized games against a card-level model of the game rules.
module tb_card_game_ctrl;

  localparam int SC = 4;
  localparam int NP = 8;
  localparam logic [1:0] OFF  = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  seed;
  logic        pick_valid;
  logic [3:0]  pick_idx;
  logic        pick_ready;
  logic        pick_err;
  logic        disp_req;
  logic [3:0]  disp_addr;
  logic [13:0] disp_data;
  logic        rf_w_enable;
  logic [3:0]  rf_w_address;
  logic [13:0] rf_w_data;
  logic [3:0]  rf_r_address;
  logic [13:0] rf_r_data;
  logic        busy;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        game_over;

  always #5 clk = ~clk;

  card_game_ctrl #(.N_PAIRS(NP), .SHOW_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .pick_valid   (pick_valid),
    .pick_idx     (pick_idx),
    .pick_ready   (pick_ready),
    .pick_err     (pick_err),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .rf_w_enable  (rf_w_enable),
    .rf_w_address (rf_w_address),
    .rf_w_data    (rf_w_data),
    .rf_r_address (rf_r_address),
    .rf_r_data    (rf_r_data),
    .busy         (busy),
    .pairs_found  (pairs_found),
    .moves        (moves),
    .game_over    (game_over)
  );

  // Register file: asynchronous read, write captured at the clock edge.
  logic [13:0] rf_mem [16];
  int          wr_count = 0;
  assign rf_r_data = rf_mem[rf_r_address];
  always @(posedge clk) begin
    if (rf_w_enable) begin
      rf_mem[rf_w_address] <= rf_w_data;
      wr_count <= wr_count + 1;
    end
  end

  // Card model: colour and face state per slot plus the score.
  logic [11:0] lut [8];
  logic [11:0] m_color [16];
  logic [1:0]  m_state [16];
  int          m_pairs, m_moves;
  bit          have_first;
  int          first_idx;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    have_first = 1'b0;
  endtask

  task automatic checkCards(input string tag);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_card%0d", tag, i), 32'(rf_mem[i]),
                  32'({m_color[i], m_state[i]}));
    end
  endtask

  task automatic dealGame(input logic [3:0] s);
    int n;
    int w0;
    seed  = s;
    start = 1'b1;
    w0    = wr_count;
    tick();
    start = 1'b0;
    checkOutput("busy_in_init", 32'(busy), 32'd1);
    n = 0;
    while (!pick_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("init_cycles", 32'(n), 32'd16);
    tick();
    checkOutput("init_writes", 32'(wr_count - w0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      m_color[i] = lut[((i + int'(s)) % 16) / 2];
      m_state[i] = DOWN;
    end
    m_pairs    = 0;
    m_moves    = 0;
    have_first = 1'b0;
    checkCards($sformatf("deal_s%0d", s));
    checkOutput("deal_pairs", 32'(pairs_found), 32'd0);
    checkOutput("deal_moves", 32'(moves), 32'd0);
    checkOutput("deal_game_over", 32'(game_over), 32'd0);
  endtask

  // One pick: optional display stall across READ, then resolve if second card.
  task automatic applyStimulus(input logic [3:0] idx, input int stall,
                               input logic [3:0] stall_addr);
    int   n;
    bit   exp_err;
    bit   is_second;
    bit   m;
    logic [1:0] st;
    n = 0;
    while (!pick_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("pick_ready_wait", 32'(pick_ready), 32'd1);
    if (!pick_ready) return;
    exp_err    = (m_state[idx] != DOWN);
    is_second  = have_first;
    pick_valid = 1'b1;
    pick_idx   = idx;
    if (stall > 0) begin
      disp_req  = 1'b1;
      disp_addr = stall_addr;
    end
    tick();
    pick_valid = 1'b0;
    pick_idx   = 4'($urandom_range(0, 15));
    checkOutput("ready_in_read", 32'(pick_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      checkOutput("stall_rd_addr", 32'(rf_r_address), 32'(stall_addr));
      checkOutput("stall_disp_data", 32'(disp_data), 32'(rf_mem[stall_addr]));
      tick();
      checkOutput("stall_no_write", 32'(rf_w_enable), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
    end
    disp_req = 1'b0;
    #1;
    checkOutput("ctrl_rd_addr", 32'(rf_r_address), 32'(idx));
    tick();
    checkOutput("pick_err", 32'(pick_err), 32'(exp_err));
    checkOutput("flip_write_en", 32'(rf_w_enable), 32'(!exp_err));
    if (exp_err) begin
      checkOutput("err_back_to_wait", 32'(pick_ready), 32'd1);
      return;
    end
    checkOutput("flip_addr", 32'(rf_w_address), 32'(idx));
    checkOutput("flip_data", 32'(rf_w_data), 32'({m_color[idx], UP}));
    m_state[idx] = UP;
    if (!is_second) begin
      have_first = 1'b1;
      first_idx  = idx;
      checkOutput("wait2_ready", 32'(pick_ready), 32'd1);
      return;
    end
    checkOutput("show_busy", 32'(busy), 32'd1);
    n = 0;
    while (!(pick_ready || game_over) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("show_res_cycles", 32'(n), 32'(SC + 2));
    m  = (m_color[first_idx] == m_color[idx]);
    st = m ? OFF : DOWN;
    m_state[first_idx] = st;
    m_state[idx]       = st;
    m_moves    = (m_moves >= 255) ? 255 : m_moves + 1;
    m_pairs    = m_pairs + int'(m);
    have_first = 1'b0;
    tick();
    checkOutput("res_card1", 32'(rf_mem[first_idx]), 32'({m_color[first_idx], st}));
    checkOutput("res_card2", 32'(rf_mem[idx]), 32'({m_color[idx], st}));
    checkOutput("pairs_found", 32'(pairs_found), 32'(m_pairs));
    checkOutput("moves", 32'(moves), 32'(m_moves));
    checkOutput("game_over", 32'(game_over), 32'(m_pairs == NP));
  endtask

  initial begin
    int w0;
    int turns;
    int c1;
    int c2;
    int q[$];
    int offq[$];
    lut = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    disp_req   = 1'b0;
    disp_addr  = '0;
    have_first = 1'b0;
    first_idx  = 0;
    m_pairs    = 0;
    m_moves    = 0;
    tick();
    checkOutput("rst_pick_ready", 32'(pick_ready), 32'd0);
    checkOutput("rst_pick_err", 32'(pick_err), 32'd0);
    checkOutput("rst_w_enable", 32'(rf_w_enable), 32'd0);
    checkOutput("rst_w_address", 32'(rf_w_address), 32'd0);
    checkOutput("rst_w_data", 32'(rf_w_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pairs", 32'(pairs_found), 32'd0);
    checkOutput("rst_moves", 32'(moves), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] deal with seed 1 and seed 0");
    dealGame(4'd1);
    doReset();
    dealGame(4'd0);

    $display("[TB] start ignored while playing");
    w0    = wr_count;
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    checkOutput("start_ignored_writes", 32'(wr_count - w0), 32'd0);
    checkOutput("start_ignored_ready", 32'(pick_ready), 32'd1);

    $display("[TB] mismatch, match, repeat pick, dead card, display stall");
    applyStimulus(4'd0, 0, 4'd0);
    applyStimulus(4'd2, 0, 4'd0);
    applyStimulus(4'd0, 0, 4'd0);
    applyStimulus(4'd1, 0, 4'd0);
    applyStimulus(4'd3, 0, 4'd0);
    applyStimulus(4'd3, 0, 4'd0);
    applyStimulus(4'd2, 0, 4'd0);
    applyStimulus(4'd0, 0, 4'd0);
    applyStimulus(4'd4, 3, 4'd5);
    applyStimulus(4'd5, 2, 4'd5);

    $display("[TB] reset during SHOW");
    applyStimulus(4'd6, 0, 4'd0);
    pick_valid = 1'b1;
    pick_idx   = 4'd8;
    tick();
    pick_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_pick_ready", 32'(pick_ready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_w_enable", 32'(rf_w_enable), 32'd0);
    checkOutput("mid_rst_w_address", 32'(rf_w_address), 32'd0);
    checkOutput("mid_rst_w_data", 32'(rf_w_data), 32'd0);
    checkOutput("mid_rst_pairs", 32'(pairs_found), 32'd0);
    checkOutput("mid_rst_moves", 32'(moves), 32'd0);
    checkOutput("mid_rst_game_over", 32'(game_over), 32'd0);
    checkOutput("mid_rst_pick_err", 32'(pick_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    have_first = 1'b0;

    $display("[TB] moves saturation");
    dealGame(4'd0);
    for (int t = 0; t < 257; t++) begin
      applyStimulus(4'd0, 0, 4'd0);
      applyStimulus(4'd2, 0, 4'd0);
    end
    checkOutput("moves_saturated", 32'(moves), 32'd255);
    doReset();

    $display("[TB] randomized full games");
    for (int g = 0; g < 3; g++) begin
      dealGame(4'($urandom_range(0, 15)));
      turns = 0;
      while (m_pairs < NP && turns < 200) begin
        q.delete();
        offq.delete();
        for (int i = 0; i < 16; i++) begin
          if (m_state[i] == DOWN) q.push_back(i);
          else offq.push_back(i);
        end
        if (offq.size() > 0 && $urandom_range(0, 3) == 0) begin
          applyStimulus(4'(offq[$urandom_range(0, offq.size() - 1)]), 0, 4'd0);
        end
        c1 = q[$urandom_range(0, q.size() - 1)];
        applyStimulus(4'(c1), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      4'($urandom_range(0, 15)));
        if ($urandom_range(0, 4) == 0) begin
          applyStimulus(4'(c1), 0, 4'd0);
        end
        q.delete();
        c2 = -1;
        for (int i = 0; i < 16; i++) begin
          if (m_state[i] == DOWN) begin
            q.push_back(i);
            if (m_color[i] == m_color[c1]) c2 = i;
          end
        end
        if (c2 < 0 || $urandom_range(0, 1) == 0) begin
          c2 = q[$urandom_range(0, q.size() - 1)];
        end
        applyStimulus(4'(c2), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      4'($urandom_range(0, 15)));
        turns++;
      end
      checkOutput("rand_game_over", 32'(game_over), 32'd1);
      checkOutput("rand_pairs", 32'(pairs_found), 32'(NP));
    end
    dealGame(4'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
